// File: rtl/inst_queue_pkg.sv
//------------------------------------------------------------------------------
// Module      : inst_queue_pkg
// Description : Shared widths and constants for the IFU->IDU instruction queue.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package inst_queue_pkg;

    localparam int          C_CPU_WIDTH = 32;
    localparam int          C_DEPTH     = 4;
    localparam logic [31:0] C_INST_NOP  = 32'h0000_0013;

endpackage : inst_queue_pkg

`default_nettype wire

// File: rtl/inst_queue_if.sv
//------------------------------------------------------------------------------
// Module      : inst_queue_if
// Description : Push (IFU side) and pop (IDU side) signal bundle of inst_queue.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface inst_queue_if
    import inst_queue_pkg::*;
#(
    parameter int CPU_WIDTH = C_CPU_WIDTH,
    parameter int DEPTH     = C_DEPTH
);
    localparam int C_CW = $clog2(DEPTH) + 1;

    logic                 flush;
    logic                 push_en;
    logic [CPU_WIDTH-1:0] push_pc;
    logic [CPU_WIDTH-1:0] push_inst;
    logic                 iq_afull;
    logic                 iq_valid;
    logic                 iq_ready;
    logic [CPU_WIDTH-1:0] idu_inst;
    logic [CPU_WIDTH-1:0] idu_inst_pc;
    logic [C_CW-1:0]      iq_count;
    logic                 iq_overflow;

    modport master (
        output flush, push_en, push_pc, push_inst, iq_ready,
        input  iq_afull, iq_valid, idu_inst, idu_inst_pc, iq_count, iq_overflow
    );

    modport slave (
        input  flush, push_en, push_pc, push_inst, iq_ready,
        output iq_afull, iq_valid, idu_inst, idu_inst_pc, iq_count, iq_overflow
    );

endinterface : inst_queue_if

`default_nettype wire

// File: rtl/inst_queue.sv
//------------------------------------------------------------------------------
// Module      : inst_queue
// Description : DEPTH-entry {pc, inst} FIFO between IFU and IDU with flush.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int          DEPTH     = C_DEPTH,
    parameter int          CPU_WIDTH = C_CPU_WIDTH,
    parameter logic [31:0] NOP_INST  = C_INST_NOP
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    inst_queue_if.slave   bus
);

    localparam int             C_AW       = $clog2(DEPTH);
    localparam int             C_PW       = C_AW + 1;
    localparam logic [C_PW-1:0] C_PTR_ONE = C_PW'(1);
    localparam logic [C_PW-1:0] C_AFULL   = C_PW'(DEPTH - 1);

    logic [CPU_WIDTH-1:0] r_mem_pc   [DEPTH];
    logic [CPU_WIDTH-1:0] r_mem_inst [DEPTH];
    logic [C_PW-1:0]      r_wr_ptr;
    logic [C_PW-1:0]      r_rd_ptr;
    logic [CPU_WIDTH-1:0] r_last_pc;
    logic                 r_overflow;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push_ok;
    logic                 w_push_drop;
    logic [CPU_WIDTH-1:0] w_head_pc;
    logic [CPU_WIDTH-1:0] w_head_inst;

    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[C_AW] != r_rd_ptr[C_AW]) &&
                         (r_wr_ptr[C_AW-1:0] == r_rd_ptr[C_AW-1:0]);
    // Flush masks both sides so a redirect cycle neither consumes nor captures.
    assign w_pop       = ~w_empty & bus.iq_ready & ~bus.flush;
    assign w_push_ok   = bus.push_en & ~bus.flush & (~w_full | w_pop);
    assign w_push_drop = bus.push_en & ~bus.flush & w_full & ~w_pop;

    assign w_head_pc   = r_mem_pc[r_rd_ptr[C_AW-1:0]];
    assign w_head_inst = r_mem_inst[r_rd_ptr[C_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem_pc[r_wr_ptr[C_AW-1:0]]   <= bus.push_pc;
            r_mem_inst[r_wr_ptr[C_AW-1:0]] <= bus.push_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_last_pc  <= '0;
            r_overflow <= 1'b0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + C_PTR_ONE;
                r_last_pc <= w_head_pc;
            end
            if (w_push_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.iq_count    = r_wr_ptr - r_rd_ptr;
    assign bus.iq_afull    = (bus.iq_count >= C_AFULL);
    assign bus.iq_valid    = ~w_empty;
    assign bus.idu_inst    = w_empty ? CPU_WIDTH'(NOP_INST) : w_head_inst;
    assign bus.idu_inst_pc = w_empty ? r_last_pc : w_head_pc;
    assign bus.iq_overflow = r_overflow;

endmodule : inst_queue

`default_nettype wire

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- FIFO of decoded-ready fetch results between IFU and IDU in the rvseed core.
- Captures {pc, inst} on each IFU completion pulse and presents the head entry to the decode stage with a valid/ready handshake.
- Discards all contents on a control-flow redirect.
- Drives the IDU's current-PC return path and a throttle signal that gates the IFU enable.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- CPU_WIDTH, 32, instruction and PC width (same as the core-wide `CPU_WIDTH).
- NOP_INST, 32'h0000_0013, instruction presented when the queue is empty (addi x0,x0,0).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset. Synchronous, active-low.
- flush  in  1  redirect pulse (branch taken / jump resolved); clears queue.
- push_en  in  1  IFU completion strobe (ifu_done_en).
- push_pc  in  CPU_WIDTH  PC of fetched instruction (ifu_inst_pc).
- push_inst  in  CPU_WIDTH  fetched instruction (ifu_inst).
- iq_afull  out  1  throttle; high when count >= DEPTH-1. IFU enable is ANDed with ~iq_afull.
- iq_valid  out  1  head entry valid.
- iq_ready  in  1  IDU accepts head this cycle.
- idu_inst  out  CPU_WIDTH  head instruction; NOP_INST when empty.
- idu_inst_pc  out  CPU_WIDTH  PC of head; holds PC of last popped entry when empty.
- iq_count  out  $clog2(DEPTH)+1  occupancy.
- iq_overflow  out  1  sticky error: push attempted while full and not popping.

Behaviour:
Storage and pointers:
- Storage: DEPTH x {pc, inst} register array.
- wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits, extra MSB used for wrap.
- empty = (wr_ptr == rd_ptr).
- full = MSBs differ and low bits are equal.
- iq_count = wr_ptr - rd_ptr, computed modulo 2^($clog2(DEPTH)+1).

Handshake:
- pop = iq_valid & iq_ready.
- push_ok = push_en & (~full | pop).
- Push writes mem[wr_ptr] on the clock edge.
- Latency: an entry pushed in cycle N is visible at the head in cycle N+1. There is no same-cycle bypass.

Outputs:
- iq_valid = ~empty.
- idu_inst = empty ? NOP_INST : mem[rd_ptr].inst.
- idu_inst_pc = empty ? last_pc_r : mem[rd_ptr].pc.
- last_pc_r updates to the head PC on every pop.

Simultaneous events:
- Push and pop in the same cycle when full: both happen, count unchanged.
- Push and pop in the same cycle when non-empty and not full: both happen, count unchanged.
- Push while full with no pop: entry is dropped, pointers unchanged, iq_overflow set to 1. iq_overflow clears only on reset.

Flush (priority over push and pop):
- wr_ptr and rd_ptr go to 0.
- A push_en asserted in the same cycle is discarded.
- No pop is reported in that cycle.
- last_pc_r is not modified.
- iq_valid is 0 in the next cycle.

Reset (rst_n low at posedge):
- Pointers 0, last_pc_r 0, iq_overflow 0.
- Resulting outputs: iq_valid 0, iq_count 0, iq_afull 0, idu_inst = NOP_INST, idu_inst_pc 0.
- Storage array is not reset.
- Reset mid-operation discards all contents on that edge.

Wrap-around:
- Pointer low bits roll from DEPTH-1 to 0. The MSB toggles on each wrap.

Decomposition:
- Shared defines file (existing core defines): `CPU_WIDTH and a new `INST_NOP (32'h0000_0013).
- No sub-module needed; the storage array is inline.
- Optional: a generic sync_fifo sub-module may be factored out if the LSU needs the same structure. It is not required for this block.

Test Plan:
- Reset then idle -> iq_valid=0, iq_count=0, idu_inst=32'h13, idu_inst_pc=0.
- Push pc=0x0 inst=0x00500093, then pc=0x4 inst=0x00100113, with iq_ready=0 -> iq_count=2. Head shows pc 0x0 one cycle after the first push. Then iq_ready=1 for 2 cycles -> pops in order, idu_inst_pc shows 0x4 after the first pop. Once empty, idu_inst_pc holds 0x4 and idu_inst=0x13.
- Fill 4 entries (DEPTH=4) -> iq_afull high from count 3. Fifth push with iq_ready=0 -> count stays 4 and iq_overflow=1. Fifth push with iq_ready=1 -> accepted, count stays 4, overflow stays 0.
- Queue at 2 entries, flush and push_en in the same cycle -> next cycle count=0, iq_valid=0, the pushed entry is lost, idu_inst_pc unchanged.
- Stream 10 push/pop pairs with continuous ready -> wrap occurs, no loss, PCs out 0x0..0x24 in order.
- rst_n low for one cycle with 3 entries queued -> all outputs at reset values on the next cycle.
